module_alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the Mini-CPU ALU. It keeps the existing 3-bit opcode set and sign-magnitude immediate, and adds:
- a `start`/`busy`/`done` handshake in place of CPU-state snooping;
- a configurable data width;
- a signed-overflow flag;
- an iterative shift-add multiplier.

It sits between the CPU control FSM and the register RAM: the FSM pulses `start` in CALC and waits for `done` before STORE.

---
 rtl/module_alu_seq.sv | 159 +++++++++++++++
 tb/tb_module_alu_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/module_alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake, signed overflow flag and iterative shift-add MUL.
// Build option: define ALU_SATURATE_EN to clamp overflowing results instead of wrapping.
module module_alu_seq #(
  parameter int WIDTH         = 16,
  parameter int IMM_MAG_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               opcode,
  input  logic                     sinalImm,
  input  logic [IMM_MAG_WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0]         v1ULA,
  input  logic [WIDTH-1:0]         v2ULA,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         valorGuardarULA,
  output logic                     overflow
);

  localparam int AW = WIDTH + IMM_MAG_WIDTH;
  localparam int CW = $clog2(IMM_MAG_WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(IMM_MAG_WIDTH - 1);
  localparam logic [AW-1:0]    HALF = {{(AW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ALU_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SUBI  = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, MULT, FIN} state_t;

  state_t                   state_q;
  logic [2:0]               op_q;
  logic [WIDTH-1:0]         v1_q, v2_q;
  logic                     sgn_q;
  logic [IMM_MAG_WIDTH-1:0] imm_q, mplier_q;
  logic [AW-1:0]            mcand_q, acc_q;
  logic [CW-1:0]            cnt_q;
  logic                     busy_q, done_q, ovf_q;
  logic [WIDTH-1:0]         res_q;

  logic [WIDTH-1:0] abs_v1;
  logic [WIDTH-1:0] imm_ext, imm_s, alu_b, alu_sum, alu_res, mul_wrap, mul_res, res_d;
  logic             alu_sub, alu_ovf, mul_neg, mul_ovf, ovf_d;

  // The most negative v1 maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  assign abs_v1 = v1ULA[WIDTH-1] ? -v1ULA : v1ULA;

  always_comb begin
    imm_ext = {{(WIDTH-IMM_MAG_WIDTH){1'b0}}, imm_q};
    imm_s   = sgn_q ? -imm_ext : imm_ext;
    alu_sub = (op_q == OP_SUB) || (op_q == OP_SUBI);
    alu_b   = ((op_q == OP_ADDI) || (op_q == OP_SUBI)) ? imm_s : v2_q;
    alu_sum = alu_sub ? (v1_q - alu_b) : (v1_q + alu_b);
    alu_ovf = (alu_sub ? (v1_q[WIDTH-1] != alu_b[WIDTH-1]) : (v1_q[WIDTH-1] == alu_b[WIDTH-1]))
              && (alu_sum[WIDTH-1] != v1_q[WIDTH-1]);
    // On overflow the true result has the sign of v1.
    alu_res = (SAT_EN && alu_ovf) ? (v1_q[WIDTH-1] ? SMIN : SMAX) : alu_sum;

    mul_neg  = v1_q[WIDTH-1] ^ (sgn_q && (imm_q != '0));
    mul_ovf  = mul_neg ? (acc_q > HALF) : (acc_q >= HALF);
    mul_wrap = mul_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    mul_res  = (SAT_EN && mul_ovf) ? (mul_neg ? SMIN : SMAX) : mul_wrap;

    res_d = res_q;
    ovf_d = ovf_q;
    if (state_q == FIN) begin
      res_d = mul_res;
      ovf_d = mul_ovf;
    end else begin
      case (op_q)
        OP_LOAD: begin
          res_d = imm_s;
          ovf_d = 1'b0;
        end
        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
          res_d = alu_res;
          ovf_d = alu_ovf;
        end
        OP_CLEAR: begin
          res_d = '0;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      sgn_q    <= 1'b0;
      imm_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= opcode;
            v1_q     <= v1ULA;
            v2_q     <= v2ULA;
            sgn_q    <= sinalImm;
            imm_q    <= Imm;
            mplier_q <= Imm;
            mcand_q  <= {{IMM_MAG_WIDTH{1'b0}}, abs_v1};
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= (opcode == OP_MUL) ? MULT : EXEC;
          end
        end
        MULT: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= FIN;
        end
        EXEC, FIN: begin
          res_q   <= res_d;
          ovf_q   <= ovf_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign valorGuardarULA = res_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_module_alu_seq.sv
// Directed bench for module_alu_seq: vector table plus hand-built handshake, ignore and reset sequences.
module tb_module_alu_seq;

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, ADDI = 3'b010, SUB = 3'b011;
  localparam logic [2:0] SUBI = 3'b100, MUL = 3'b101, CLEAR = 3'b110, DISPLAY = 3'b111;

  logic        clk, rst, start, sinalImm, busy, done, overflow;
  logic [2:0]  opcode;
  logic [5:0]  Imm;
  logic [15:0] v1ULA, v2ULA, valorGuardarULA;

  int n_checks = 0;
  int n_errors = 0;

  module_alu_seq #(.WIDTH(16), .IMM_MAG_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .sinalImm(sinalImm), .Imm(Imm),
    .v1ULA(v1ULA), .v2ULA(v2ULA), .busy(busy), .done(done),
    .valorGuardarULA(valorGuardarULA), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        sgn;
    logic [5:0]  imm;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [2:0] op, input logic sgn, input logic [5:0] imm,
                              input logic [15:0] v1, input logic [15:0] v2,
                              input logic [15:0] res, input logic ovf, input int lat);
    vec_t v;
    v.op = op; v.sgn = sgn; v.imm = imm; v.v1 = v1; v.v2 = v2;
    v.res = res; v.ovf = ovf; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    @(negedge clk);
    opcode = v.op; sinalImm = v.sgn; Imm = v.imm; v1ULA = v.v1; v2ULA = v.v2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opcode = CLEAR; sinalImm = ~v.sgn; Imm = 6'h2A; v1ULA = 16'h5A5A; v2ULA = 16'h1234;
    check($sformatf("v%0d_busy", idx), busy, 1);
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("v%0d_latency", idx), k, v.lat);
    check($sformatf("v%0d_result", idx), valorGuardarULA, v.res);
    check($sformatf("v%0d_overflow", idx), overflow, v.ovf);
    check($sformatf("v%0d_busy_end", idx), busy, 0);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), done, 0);
  endtask

  initial begin
    int ndone;
    vecs[0]  = mk(LOAD,    1, 5,  16'h0000, 16'h0000, 16'hFFFB, 0, 1);
    vecs[1]  = mk(ADD,     0, 0,  16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 1, 1);
    vecs[2]  = mk(ADD,     0, 0,  16'h0005, 16'h0003, 16'h0008, 0, 1);
    vecs[3]  = mk(ADDI,    1, 32, 16'h0010, 16'h0000, 16'hFFF0, 0, 1);
    vecs[4]  = mk(SUB,     0, 0,  16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1, 1);
    vecs[5]  = mk(SUB,     0, 0,  16'h0003, 16'h0005, 16'hFFFE, 0, 1);
    vecs[6]  = mk(SUBI,    1, 63, 16'h7FF0, 16'h0000, SAT ? 16'h7FFF : 16'h802F, 1, 1);
    vecs[7]  = mk(CLEAR,   0, 0,  16'h1111, 16'h2222, 16'h0000, 0, 1);
    vecs[8]  = mk(ADD,     0, 0,  16'h8000, 16'h8000, SAT ? 16'h8000 : 16'h0000, 1, 1);
    vecs[9]  = mk(DISPLAY, 0, 9,  16'h0101, 16'h0202, SAT ? 16'h8000 : 16'h0000, 1, 1);
    vecs[10] = mk(SUB,     0, 0,  16'h0000, 16'h8000, SAT ? 16'h7FFF : 16'h8000, 1, 1);
    vecs[11] = mk(LOAD,    1, 0,  16'h0000, 16'h0000, 16'h0000, 0, 1);
    vecs[12] = mk(MUL,     1, 63, 16'd300,  16'h0000, 16'hB62C, 0, 7);
    vecs[13] = mk(MUL,     0, 63, 16'd1000, 16'h0000, SAT ? 16'h7FFF : 16'hF618, 1, 7);
    vecs[14] = mk(MUL,     0, 1,  16'h8000, 16'h0000, 16'h8000, 0, 7);
    vecs[15] = mk(MUL,     1, 1,  16'h8000, 16'h0000, SAT ? 16'h7FFF : 16'h8000, 1, 7);
    vecs[16] = mk(MUL,     1, 0,  16'hFFFB, 16'h0000, 16'h0000, 0, 7);
    vecs[17] = mk(MUL,     1, 3,  16'hFFF9, 16'h0000, 16'h0015, 0, 7);

    rst = 1'b1; start = 1'b0; opcode = LOAD; sinalImm = 1'b0; Imm = '0; v1ULA = '0; v2ULA = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", valorGuardarULA, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Start held through the done cycle: ignored while in EXEC, accepted once back in IDLE.
    @(negedge clk);
    opcode = LOAD; sinalImm = 1'b0; Imm = 6'd3; start = 1'b1;
    @(negedge clk);
    opcode = ADDI; v1ULA = 16'd10; Imm = 6'd4;
    @(negedge clk);
    check("b2b_done1", done, 1);
    check("b2b_res1", valorGuardarULA, 16'h0003);
    @(negedge clk);
    start = 1'b0;
    check("b2b_mid_done", done, 0);
    check("b2b_mid_busy", busy, 1);
    @(negedge clk);
    check("b2b_done2", done, 1);
    check("b2b_res2", valorGuardarULA, 16'h000E);

    // MUL with ADD start pulses landing on edges 2 and 4; neither may run.
    @(negedge clk);
    opcode = MUL; sinalImm = 1'b1; Imm = 6'd63; v1ULA = 16'd300; v2ULA = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 2 || c == 4) begin
        start = 1'b1; opcode = ADD; v1ULA = 16'd1; v2ULA = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check($sformatf("ign_done_c%0d", c), done, 32'(c == 7));
      check($sformatf("ign_busy_c%0d", c), busy, 32'(c < 7));
    end
    start = 1'b0;
    check("ign_result", valorGuardarULA, 16'hB62C);
    run_vec(mk(DISPLAY, 0, 0, 16'h0000, 16'h0000, 16'hB62C, 0, 1), 100);

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk);
    opcode = MUL; sinalImm = 1'b0; Imm = 6'd63; v1ULA = 16'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", valorGuardarULA, 0);
    check("arst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("arst_no_done", ndone, 0);
    check("arst_idle_busy", busy, 0);
    run_vec(mk(LOAD, 0, 7, 16'h0000, 16'h0000, 16'h0007, 0, 1), 101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
